// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: buffers read/write requests and issues them one at a time to a single-port memory.
// Latency: a request accepted at edge N drives mem_en in cycle N+2; writes issue every 2 cycles.
// Backpressure: req_ready drops when the request FIFO is full; the FSM holds in RESP while rsp_ready=0.
// Optional read watchdog is built when MEM_REQ_CTRL_TIMEOUT_EN is defined.

// mem_req_fifo: generic synchronous FIFO with a combinational head.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: full blocks pushes; push and pop in the same cycle keep the count.
module mem_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = store[rd_ptr];

  // Data storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// mem_req_ctrl: request FIFO plus IDLE/ISSUE/WAIT_RD/RESP sequencer in front of the memory.
// Latency: mem_en one cycle after the entry reaches the FIFO head; response one cycle after mem_valid_out.
// Backpressure: req_ready = !fifo_full; RESP waits for rsp_ready while the FIFO keeps filling.
module mem_req_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid_out
);
  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  if (FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mem_req_ctrl: FIFO_DEPTH and TIMEOUT_CYCLES must be >= 2");
  end

  state_t state;
  req_t   push_req;
  req_t   head_req;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_pop;

  assign push_req  = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;

  mem_req_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (req_valid && req_ready),
    .push_dat (push_req),
    .pop      (fifo_pop),
    .head_dat (head_req),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef MEM_REQ_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wdog;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
      rsp_err     <= 1'b0;
      wdog        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state       <= ISSUE;
            mem_en      <= 1'b1;
            mem_wr      <= head_req.wr;
            mem_addr    <= head_req.addr;
            mem_data_in <= head_req.wdata;
          end
        end
        ISSUE: begin
          // mem_wr still holds the issued entry's direction here.
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          state  <= mem_wr ? IDLE : WAIT_RD;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
          wdog   <= '0;
`endif
        end
        WAIT_RD: begin
          // Data arriving on the expiry cycle takes priority over the timeout.
          if (mem_valid_out) begin
            rsp_rdata <= mem_data_out;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
          else if (wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
